// File: rtl/pulse_generator_array.sv
// pulse_generator_array: NCH independent delayed-pulse channels.
// Each channel waits for a rising edge of (enable & pulseStart). It then
// waits delayCfg cycles and drives pulseN low for widthCfg cycles.
// Both configuration values are captured when the edge is seen.
// Optional feature macro: PULSEGEN_RETRIGGER_EN. When it is defined, an edge
// that arrives while the pulse is low restarts the pulse width from the
// current widthCfg value.
module pulse_generator_array #(
  parameter int NCH  = 4,
  parameter int CNTW = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NCH-1:0]  enable,
  input  logic [NCH-1:0]  pulseStart,
  input  logic [CNTW-1:0] delayCfg,
  input  logic [CNTW-1:0] widthCfg,
  output logic [NCH-1:0]  pulseN,
  output logic [NCH-1:0]  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    PULSE = 2'd2
  } state_t;

  localparam logic [CNTW-1:0] ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] ZERO = '0;

  state_t          state [NCH];
  logic [CNTW-1:0] cnt   [NCH];
  // Width captured at the trigger edge. It is used on entry to PULSE from DELAY.
  logic [CNTW-1:0] wlat  [NCH];
  logic [NCH-1:0]  startd;
  logic [NCH-1:0]  start;
  logic [NCH-1:0]  edge_det;

  // Gated trigger and its rising-edge detect against the previous cycle.
  assign start    = enable & pulseStart;
  assign edge_det = start & ~startd;

  // Per-channel FSM, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      startd <= '0;
      pulseN <= '1;
      busy   <= '0;
      for (int i = 0; i < NCH; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= ZERO;
        wlat[i]  <= ZERO;
      end
    end else begin
      startd <= start;
      for (int i = 0; i < NCH; i++) begin
        case (state[i])
          IDLE: begin
            // A zero-width request produces no pulse, so it is dropped here.
            if (edge_det[i] && (widthCfg != ZERO)) begin
              wlat[i] <= widthCfg;
              busy[i] <= 1'b1;
              if (delayCfg == ZERO) begin
                state[i]  <= PULSE;
                cnt[i]    <= widthCfg - ONE;
                pulseN[i] <= 1'b0;
              end else begin
                state[i] <= DELAY;
                cnt[i]   <= delayCfg - ONE;
              end
            end
          end
          DELAY: begin
            if (!enable[i]) begin
              state[i]  <= IDLE;
              cnt[i]    <= ZERO;
              pulseN[i] <= 1'b1;
              busy[i]   <= 1'b0;
            end else if (cnt[i] == ZERO) begin
              state[i]  <= PULSE;
              cnt[i]    <= wlat[i] - ONE;
              pulseN[i] <= 1'b0;
            end else begin
              cnt[i] <= cnt[i] - ONE;
            end
          end
          PULSE: begin
            if (!enable[i]) begin
              state[i]  <= IDLE;
              cnt[i]    <= ZERO;
              pulseN[i] <= 1'b1;
              busy[i]   <= 1'b0;
`ifdef PULSEGEN_RETRIGGER_EN
            end else if (edge_det[i]) begin
              // Restart the width from the current configuration value.
              // A zero width ends the pulse at once.
              if (widthCfg == ZERO) begin
                state[i]  <= IDLE;
                cnt[i]    <= ZERO;
                pulseN[i] <= 1'b1;
                busy[i]   <= 1'b0;
              end else begin
                cnt[i] <= widthCfg - ONE;
              end
`endif
            end else if (cnt[i] == ZERO) begin
              state[i]  <= IDLE;
              pulseN[i] <= 1'b1;
              busy[i]   <= 1'b0;
            end else begin
              cnt[i] <= cnt[i] - ONE;
            end
          end
          default: begin
            state[i]  <= IDLE;
            cnt[i]    <= ZERO;
            pulseN[i] <= 1'b1;
            busy[i]   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_generator_array.sv
// tb_pulse_generator_array: scenario tasks for pulse_generator_array.
// Each task pushes the expected per-cycle pulseN/busy vectors onto a queue.
// It then drives the stimulus and pops one entry after every clock edge.
module tb_pulse_generator_array;

  localparam int NCH  = 4;
  localparam int CNTW = 4;

  logic            clk;
  logic            rstn;
  logic [NCH-1:0]  enable;
  logic [NCH-1:0]  pulseStart;
  logic [CNTW-1:0] delayCfg;
  logic [CNTW-1:0] widthCfg;
  logic [NCH-1:0]  pulseN;
  logic [NCH-1:0]  busy;

  typedef struct packed {
    logic [NCH-1:0] pn;
    logic [NCH-1:0] bz;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   tests_run = 0;
  int   tests_failed = 0;

  pulse_generator_array #(.NCH(NCH), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .enable     (enable),
    .pulseStart (pulseStart),
    .delayCfg   (delayCfg),
    .widthCfg   (widthCfg),
    .pulseN     (pulseN),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge. Outputs are read 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns 1 when k lies in the half-open window [a, b).
  function automatic logic inw(int k, int a, int b);
    return (k >= a) && (k < b);
  endfunction

  task automatic test_reset();
    rstn = 1'b0; enable = '1; pulseStart = '0; delayCfg = '0; widthCfg = '0;
    for (int k = 0; k < 3; k++) exp_q.push_back('{pn: 4'b1111, bz: 4'b0000});
    for (int k = 0; k < 3; k++) begin
      if (k == 2) rstn = 1'b1;
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if (pulseN !== e.pn || busy !== e.bz) begin
        tests_failed++;
        $display("FAIL reset cyc %0d: pulseN=%b busy=%b, want pulseN=%b busy=%b", k, pulseN, busy, e.pn, e.bz);
      end
    end
  endtask

  task automatic test_basic();
    for (int k = 0; k < 6; k++)
      exp_q.push_back('{pn: {3'b111, !inw(k, 0, 3)}, bz: {3'b000, inw(k, 0, 3)}});
    delayCfg = 4'd0; widthCfg = 4'd3;
    for (int k = 0; k < 6; k++) begin
      pulseStart = (k == 0) ? 4'b0001 : 4'b0000;
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if (pulseN !== e.pn || busy !== e.bz) begin
        tests_failed++;
        $display("FAIL basic cyc %0d: pulseN=%b busy=%b, want pulseN=%b busy=%b", k, pulseN, busy, e.pn, e.bz);
      end
    end
  endtask

  task automatic test_delay_latch();
    for (int k = 0; k < 10; k++)
      exp_q.push_back('{pn: {3'b111, !inw(k, 5, 7)}, bz: {3'b000, inw(k, 0, 7)}});
    delayCfg = 4'd5; widthCfg = 4'd2;
    for (int k = 0; k < 10; k++) begin
      pulseStart = (k == 0) ? 4'b0001 : 4'b0000;
      if (k == 1) begin delayCfg = 4'd1; widthCfg = 4'd7; end
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if (pulseN !== e.pn || busy !== e.bz) begin
        tests_failed++;
        $display("FAIL delay_latch cyc %0d: pulseN=%b busy=%b, want pulseN=%b busy=%b", k, pulseN, busy, e.pn, e.bz);
      end
    end
  endtask

  task automatic test_width_bounds();
    // A W=0 edge at k=0 is ignored. A W=15 edge at k=4 is low for 15 cycles.
    for (int k = 0; k < 22; k++)
      exp_q.push_back('{pn: {3'b111, !inw(k, 4, 19)}, bz: {3'b000, inw(k, 4, 19)}});
    delayCfg = 4'd0; widthCfg = 4'd0;
    for (int k = 0; k < 22; k++) begin
      pulseStart = (k < 2 || k == 4 || k == 5) ? 4'b0001 : 4'b0000;
      if (k == 4) widthCfg = 4'd15;
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if (pulseN !== e.pn || busy !== e.bz) begin
        tests_failed++;
        $display("FAIL width_bounds cyc %0d: pulseN=%b busy=%b, want pulseN=%b busy=%b", k, pulseN, busy, e.pn, e.bz);
      end
    end
  endtask

  task automatic test_retrigger();
    int hi;
`ifdef PULSEGEN_RETRIGGER_EN
    hi = 6;
`else
    hi = 4;
`endif
    for (int k = 0; k < 9; k++)
      exp_q.push_back('{pn: {2'b11, !inw(k, 0, hi), 1'b1}, bz: {2'b00, inw(k, 0, hi), 1'b0}});
    delayCfg = 4'd0; widthCfg = 4'd4;
    for (int k = 0; k < 9; k++) begin
      pulseStart = (k == 0 || k == 2) ? 4'b0010 : 4'b0000;
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if (pulseN !== e.pn || busy !== e.bz) begin
        tests_failed++;
        $display("FAIL retrigger cyc %0d: pulseN=%b busy=%b, want pulseN=%b busy=%b", k, pulseN, busy, e.pn, e.bz);
      end
    end
  endtask

  task automatic test_abort();
    logic o_lo, o_bz, c_lo, c_bz;
    for (int k = 0; k < 9; k++) begin
      o_lo = inw(k, 3, 7); o_bz = inw(k, 0, 7);
      c_lo = inw(k, 3, 5); c_bz = inw(k, 0, 5);
      exp_q.push_back('{pn: {!o_lo, !c_lo, !o_lo, !o_lo}, bz: {o_bz, c_bz, o_bz, o_bz}});
    end
    delayCfg = 4'd3; widthCfg = 4'd4;
    for (int k = 0; k < 9; k++) begin
      pulseStart = (k < 8) ? 4'b1111 : 4'b0000;
      enable = (k >= 5) ? 4'b1011 : 4'b1111;
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if (pulseN !== e.pn || busy !== e.bz) begin
        tests_failed++;
        $display("FAIL abort cyc %0d: pulseN=%b busy=%b, want pulseN=%b busy=%b", k, pulseN, busy, e.pn, e.bz);
      end
    end
    enable = 4'b1111;
  endtask

  task automatic test_reset_mid();
    logic lo;
    for (int k = 0; k < 11; k++) begin
      lo = (k == 0) || inw(k, 3, 9);
      exp_q.push_back('{pn: {!lo, 3'b111}, bz: {lo, 3'b000}});
    end
    delayCfg = 4'd0; widthCfg = 4'd6;
    for (int k = 0; k < 11; k++) begin
      pulseStart = (k < 4) ? 4'b1000 : 4'b0000;
      rstn = !(k == 1 || k == 2);
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if (pulseN !== e.pn || busy !== e.bz) begin
        tests_failed++;
        $display("FAIL reset_mid cyc %0d: pulseN=%b busy=%b, want pulseN=%b busy=%b", k, pulseN, busy, e.pn, e.bz);
      end
    end
    rstn = 1'b1;
  endtask

  task automatic test_back_to_back();
    // ch0 and ch2 use D=2,W=2 from k=0. ch1 uses D=0,W=1 from k=1.
    // The ch0 edge at k=2 falls in DELAY and is ignored.
    logic a_lo, a_bz, b_lo;
    for (int k = 0; k < 7; k++) begin
      a_lo = inw(k, 2, 4); a_bz = inw(k, 0, 4); b_lo = inw(k, 1, 2);
      exp_q.push_back('{pn: {1'b1, !a_lo, !b_lo, !a_lo}, bz: {1'b0, a_bz, b_lo, a_bz}});
    end
    delayCfg = 4'd2; widthCfg = 4'd2;
    for (int k = 0; k < 7; k++) begin
      case (k)
        0: pulseStart = 4'b0101;
        1: begin pulseStart = 4'b0110; delayCfg = 4'd0; widthCfg = 4'd1; end
        2: pulseStart = 4'b0111;
        default: pulseStart = 4'b0000;
      endcase
      tick();
      e = exp_q.pop_front();
      tests_run++;
      if (pulseN !== e.pn || busy !== e.bz) begin
        tests_failed++;
        $display("FAIL back_to_back cyc %0d: pulseN=%b busy=%b, want pulseN=%b busy=%b", k, pulseN, busy, e.pn, e.bz);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delay_latch();
    test_width_bounds();
    test_retrigger();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
